// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory hold-off
module lif_neuron #(
    parameter int DATA_W     = 8,
    parameter int V_W        = 16,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int V_RESET    = 0,
    parameter int REFRACTORY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_current,
    output logic              spike
);

    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [V_W-1:0] THR   = THRESHOLD[V_W-1:0];
    localparam logic [V_W-1:0] V_RST = V_RESET[V_W-1:0];
    localparam logic [RW-1:0]  REFR  = REFRACTORY[RW-1:0];

    logic [V_W-1:0] v_q, v_d;
    logic [RW-1:0]  refr_q, refr_d;
    logic           spike_q, spike_d;

    logic [V_W-1:0] leak;
    logic [V_W:0]   v_sum;
    logic [V_W-1:0] v_sat;

    // Leaked value never exceeds v, so only the added current can overflow V_W bits.
    assign leak  = v_q >> LEAK_SHIFT;
    assign v_sum = {1'b0, v_q} - {1'b0, leak}
                 + {{(V_W + 1 - DATA_W){1'b0}}, input_current};
    assign v_sat = v_sum[V_W] ? {V_W{1'b1}} : v_sum[V_W-1:0];

    always_comb begin
        v_d     = v_q;
        refr_d  = refr_q;
        spike_d = 1'b0;
        if (refr_q != '0) begin
            refr_d = refr_q - 1'b1;
            v_d    = V_RST;
        end else if (v_sat >= THR) begin
            spike_d = 1'b1;
            v_d     = V_RST;
            refr_d  = REFR;
        end else begin
            v_d = v_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - self-checking bench for lif_neuron against an arithmetic reference model
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] input_current;
    logic       spike;

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk           (clk),
        .reset         (reset),
        .input_current (input_current),
        .spike         (spike)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: potential, remaining refractory edges, expected spike
    int mv = 0;
    int mr = 0;
    int ms = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cur, input bit rst);
        int n;
        @(negedge clk);
        input_current = cur[7:0];
        reset         = rst;
        @(posedge clk);
        if (!rst) begin
            mv = 0; mr = 0; ms = 0;
        end else if (mr > 0) begin
            mr = mr - 1; mv = 0; ms = 0;
        end else begin
            n = mv - mv / 8 + cur;
            if (n > 65535) n = 65535;
            if (n >= 200) begin
                ms = 1; mv = 0; mr = 2;
            end else begin
                ms = 0; mv = n;
            end
        end
        #1;
    endtask

    initial begin
        int spikes;
        int prev;
        reset         = 1'b0;
        input_current = 8'd255;

        // Reset held with full input
        for (int k = 0; k < 2; k++) begin
            step(255, 1'b0);
            check("reset_hold", {31'b0, spike}, 0);
        end
        spikes = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1'b1);
            spikes += int'(spike);
        end
        check("zero_input_spikes", spikes, 0);

        // Constant 50: first spike on 6th integrating edge, then every 8
        step(0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step(50, 1'b1);
            check("const50_pattern", {31'b0, spike},
                  (k >= 6 && (k - 6) % 8 == 0) ? 1 : 0);
            check("const50_model", {31'b0, spike}, ms);
        end

        // Constant 20 settles below threshold
        step(0, 1'b0);
        spikes = 0;
        for (int k = 0; k < 1000; k++) begin
            step(20, 1'b1);
            spikes += int'(spike);
            if (spike !== 1'(ms)) check("const20_model", {31'b0, spike}, ms);
        end
        check("const20_spikes", spikes, 0);

        // Saturating input: fire, two ignored edges, fire again
        step(0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(255, 1'b1);
            check("in255_pattern", {31'b0, spike}, (k % 3 == 1) ? 1 : 0);
        end

        // Reset in the middle of integration
        step(0, 1'b0);
        for (int k = 0; k < 5; k++) step(50, 1'b1);
        step(50, 1'b0);
        check("mid_reset_no_spike", {31'b0, spike}, 0);
        for (int k = 1; k <= 6; k++) begin
            step(50, 1'b1);
            check("post_reset_restart", {31'b0, spike}, (k == 6) ? 1 : 0);
        end

        // Randomized stimulus against the model
        step(0, 1'b0);
        prev = 0;
        for (int k = 0; k < 100; k++) begin
            step(int'($urandom_range(0, 50)), 1'b1);
            check("random_model", {31'b0, spike}, ms);
            check("random_no_b2b", (prev == 1 && spike === 1'b1) ? 1 : 0, 0);
            prev = int'(spike);
        end

        // Random with wider input and occasional reset
        for (int k = 0; k < 200; k++) begin
            step(int'($urandom_range(0, 255)), ($urandom_range(0, 15) != 0));
            check("random_wide_model", {31'b0, spike}, ms);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
